// File: rtl/acc_requant_out.sv
// acc_requant_out: requantises signed accumulator results to int8 (bias, scale, rounding shift, saturate) into a credit-controlled output FIFO.
// Optional macro RELU_STAGE_EN clamps negative results to zero before saturation.
module acc_requant_out #(
   parameter int ACC_W      = 21,
   parameter int SCALE_W    = 8,
   parameter int SHIFT_W    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_load,
   input  logic signed [ACC_W-1:0]   cfg_bias,
   input  logic [SCALE_W-1:0]        cfg_scale,
   input  logic [SHIFT_W-1:0]        cfg_shift,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [ACC_W-1:0]   in_acc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_data,
   output logic                      busy,
   output logic [7:0]                sat_count
);
   localparam int SW = ACC_W + 1;
   localparam int PW = ACC_W + SCALE_W + 2;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic signed [ACC_W-1:0] bias;
   logic [SCALE_W-1:0]      scale;
   logic [SHIFT_W-1:0]      shift;
   logic                    v1, v2, v3;
   logic signed [SW-1:0]    sum;
   logic signed [PW-1:0]    prod;
   logic [7:0]              res;
   logic                    clip;
   logic [7:0]              mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             occ;
   logic [AW+1:0]           pend;
   logic                    accept, load, push, pop;
   logic signed [PW:0]      rnd, rsh;
   logic [7:0]              sat_res, head_next;
   logic                    sat_clip;

   assign accept    = in_valid & in_ready;
   assign load      = cfg_load & ~busy & ~accept;
   assign push      = v3;
   assign pop       = out_valid & out_ready;
   assign out_valid = occ != '0;
   assign busy      = v1 | v2 | v3 | out_valid;
   // credits: queued entries plus everything still in the pipeline
   assign pend      = {1'b0, occ} + (AW+2)'(v1) + (AW+2)'(v2) + (AW+2)'(v3);
   assign in_ready  = pend < (AW+2)'(FIFO_DEPTH);

   always_comb begin
      rnd = shift == '0 ? '0 : (PW+1)'(1) << (shift - 1'b1);
      rsh = ((PW+1)'(prod) + rnd) >>> shift;
`ifdef RELU_STAGE_EN
      sat_res  = rsh > 127 ? 8'h7f : rsh < 0 ? 8'h00 : rsh[7:0];
      sat_clip = rsh > 127;
`else
      sat_res  = rsh > 127 ? 8'h7f : rsh < -128 ? 8'h80 : rsh[7:0];
      sat_clip = rsh > 127 || rsh < -128;
`endif
      head_next = pop ? (occ > 1 ? mem[rd_ptr + 1'b1] : push ? res : out_data)
                      : (occ == '0 && push ? res : out_data);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bias      <= '0;
         scale     <= SCALE_W'(1);
         shift     <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         out_data  <= '0;
         sat_count <= '0;
      end else begin
         if (load) begin
            bias  <= cfg_bias;
            scale <= cfg_scale;
            shift <= cfg_shift;
         end
         v1   <= accept;
         v2   <= v1;
         v3   <= v2;
         sum  <= SW'(in_acc) + SW'(bias);
         prod <= PW'(sum) * PW'($signed({1'b0, scale}));
         res  <= sat_res;
         clip <= sat_clip;
         if (push) begin
            mem[wr_ptr] <= res;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         occ       <= occ + (AW+1)'(push) - (AW+1)'(pop);
         out_data  <= head_next;
         sat_count <= load ? 8'd0 : (push && clip && sat_count != 8'hff) ? sat_count + 8'd1 : sat_count;
      end
   end
endmodule

// File: tb/tb_acc_requant_out.sv
// tb_acc_requant_out: directed self-checking bench for acc_requant_out.
module tb_acc_requant_out;
   logic        clk = 1'b0;
   logic        reset, cfg_load, in_valid, in_ready, out_valid, out_ready, busy;
   logic [20:0] cfg_bias, in_acc;
   logic [7:0]  cfg_scale, out_data, sat_count;
   logic [4:0]  cfg_shift;
   int          checks = 0;
   int          errors = 0;

   acc_requant_out dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_bias(cfg_bias),
      .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .in_valid(in_valid),
      .in_ready(in_ready), .in_acc(in_acc), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      in_valid = 1'b0;
      cfg_load = 1'b0;
      tick;
      reset = 1'b0;
   endtask

   task automatic run_one(input int v, output logic [7:0] d, output logic ok);
      in_valid = 1'b1;
      in_acc = 21'(v);
      tick;
      in_valid = 1'b0;
      ok = 1'b0;
      d = 8'h00;
      for (int i = 0; i < 10 && !ok; i++) begin
         tick;
         if (out_valid) begin
            ok = 1'b1;
            d = out_data;
         end
      end
      tick;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (sat_count !== 8'd0) begin errors++; $display("FAIL reset_sat: got %0d expected 0", sat_count); end
   endtask

   task automatic test_defaults;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_acc = 21'(100);
      tick;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e1: got %b expected 0", out_valid); end
      in_acc = 21'(-300);
      tick;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e2: got %b expected 0", out_valid); end
      tick;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_e3: got %b expected 0", out_valid); end
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h64) begin errors++; $display("FAIL first_out: got v=%b d=%h expected v=1 d=64", out_valid, out_data); end
      tick;
      checks += 2;
      if (out_valid !== 1'b1 || out_data !== 8'h80) begin errors++; $display("FAIL second_out: got v=%b d=%h expected v=1 d=80", out_valid, out_data); end
      if (sat_count !== 8'd1) begin errors++; $display("FAIL default_sat: got %0d expected 1", sat_count); end
      tick;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL default_drain: got v=%b busy=%b expected 0 0", out_valid, busy); end
   endtask

   task automatic test_config;
      logic [7:0] d;
      logic       ok;
      cfg_bias = 21'(-1000);
      cfg_scale = 8'd3;
      cfg_shift = 5'd2;
      cfg_load = 1'b1;
      tick;
      cfg_load = 1'b0;
      checks++;
      if (sat_count !== 8'd0) begin errors++; $display("FAIL cfg_sat_clear: got %0d expected 0", sat_count); end
      run_one(1100, d, ok);
      checks++;
      if (!ok || d !== 8'h4b) begin errors++; $display("FAIL cfg_1100: got ok=%b d=%h expected 4b", ok, d); end
      run_one(900, d, ok);
      checks++;
      if (!ok || d !== 8'hb5) begin errors++; $display("FAIL cfg_900: got ok=%b d=%h expected b5", ok, d); end
      run_one(2000, d, ok);
      checks += 2;
      if (!ok || d !== 8'h7f) begin errors++; $display("FAIL cfg_2000: got ok=%b d=%h expected 7f", ok, d); end
      if (sat_count !== 8'd1) begin errors++; $display("FAIL cfg_sat: got %0d expected 1", sat_count); end
   endtask

   task automatic test_back_to_back;
      int   accepts = 0;
      logic acc_now;
      do_reset;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_acc = 21'(accepts + 1);
         acc_now = in_ready;
         tick;
         if (acc_now) accepts++;
      end
      in_valid = 1'b0;
      checks += 2;
      if (accepts != 8) begin errors++; $display("FAIL bp_accepts: got %0d expected 8", accepts); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'(k)) begin errors++; $display("FAIL bp_order_%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, 8'(k)); end
         tick;
      end
      checks += 2;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_config_busy;
      logic [7:0] d;
      logic       ok;
      do_reset;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_acc = 21'(10);
      tick;
      in_valid = 1'b0;
      cfg_bias = 21'(0);
      cfg_scale = 8'd2;
      cfg_shift = 5'd0;
      cfg_load = 1'b1;
      tick;
      cfg_load = 1'b0;
      ok = 1'b0;
      d = 8'h00;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            d = out_data;
         end else tick;
      end
      tick;
      checks += 2;
      if (!ok || d !== 8'h0a) begin errors++; $display("FAIL busy_cfg_ignored: got ok=%b d=%h expected 0a", ok, d); end
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", busy); end
      cfg_load = 1'b1;
      tick;
      cfg_load = 1'b0;
      run_one(10, d, ok);
      checks++;
      if (!ok || d !== 8'h14) begin errors++; $display("FAIL idle_cfg_applied: got ok=%b d=%h expected 14", ok, d); end
   endtask

   task automatic test_reset_mid;
      int stale = 0;
      do_reset;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_acc = i == 0 ? 21'(1000) : 21'(i + 1);
         tick;
      end
      in_valid = 1'b0;
      checks += 2;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_state: got busy=%b v=%b expected 1 1", busy, out_valid); end
      if (sat_count !== 8'd1) begin errors++; $display("FAIL mid_pre_sat: got %0d expected 1", sat_count); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
      if (sat_count !== 8'd0) begin errors++; $display("FAIL mid_sat: got %0d expected 0", sat_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) stale++;
         tick;
      end
      checks++;
      if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d stale cycles expected 0", stale); end
   endtask

   task automatic test_relu;
      logic [7:0] d;
      logic [7:0] neg_exp;
      logic       ok;
`ifdef RELU_STAGE_EN
      neg_exp = 8'h00;
`else
      neg_exp = 8'hfb;
`endif
      do_reset;
      out_ready = 1'b1;
      run_one(-5, d, ok);
      checks += 2;
      if (!ok || d !== neg_exp) begin errors++; $display("FAIL neg5: got ok=%b d=%h expected %h", ok, d, neg_exp); end
      if (sat_count !== 8'd0) begin errors++; $display("FAIL neg5_sat: got %0d expected 0", sat_count); end
      run_one(300, d, ok);
      checks += 2;
      if (!ok || d !== 8'h7f) begin errors++; $display("FAIL pos300: got ok=%b d=%h expected 7f", ok, d); end
      if (sat_count !== 8'd1) begin errors++; $display("FAIL pos300_sat: got %0d expected 1", sat_count); end
   endtask

   initial begin
      reset = 1'b1;
      cfg_load = 1'b0;
      cfg_bias = '0;
      cfg_scale = '0;
      cfg_shift = '0;
      in_valid = 1'b0;
      in_acc = '0;
      out_ready = 1'b0;
      test_reset;
      test_defaults;
      test_config;
      test_back_to_back;
      test_config_busy;
      test_reset_mid;
      test_relu;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
